// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: computes A - B - Bin one bit per clock, LSB first,
// with a start/busy/done handshake, a serial difference stream and a parallel result.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             input_clk,
    input  logic             input_rst,
    input  logic             input_start,
    input  logic [WIDTH-1:0] input_a,
    input  logic [WIDTH-1:0] input_b,
    input  logic             input_bin,
    output logic             output_busy_o,
    output logic             output_done_o,
    output logic [WIDTH-1:0] output_diff_o,
    output logic             output_bout_o,
    output logic             output_serial_o,
    output logic             output_serial_valid_o
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Full-subtractor cell: returns {borrow_out, difference}.
    function automatic logic [1:0] full_sub(input logic a, input logic b, input logic br);
        return {(~a & b) | (~(a ^ b) & br), a ^ b ^ br};
    endfunction

    state_t           state_r;
    state_t           state_next_s;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] dif_r;
    logic [WIDTH-1:0] diff_r;
    logic             bout_r;
    logic             br_r;
    logic [CNT_W-1:0] cnt_r;
    logic             load_s;
    logic             shift_s;
    logic             finish_s;
    logic             d_s;
    logic             br_next_s;

    // Subtractor cell on the current LSBs and the running borrow.
    always_comb begin
        {br_next_s, d_s} = full_sub(a_r[0], b_r[0], br_r);
    end

    // Next-state and datapath strobes.
    always_comb begin
        state_next_s = state_r;
        load_s       = 1'b0;
        shift_s      = 1'b0;
        finish_s     = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (input_start) begin
                    load_s       = 1'b1;
                    state_next_s = ST_SHIFT;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                shift_s = 1'b1;
                if (cnt_r == LAST_CNT) begin
                    finish_s     = 1'b1;
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_SHIFT;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State register; busy/done are registered decodes of the next state.
    always_ff @(posedge input_clk) begin
        if (input_rst) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s == ST_SHIFT);
            done_r  <= (state_next_s == ST_DONE);
        end
    end

    // Operand capture, bit-serial shifting and result publication.
    always_ff @(posedge input_clk) begin
        if (input_rst) begin
            a_r    <= '0;
            b_r    <= '0;
            dif_r  <= '0;
            diff_r <= '0;
            bout_r <= 1'b0;
            br_r   <= 1'b0;
            cnt_r  <= '0;
        end else if (load_s) begin
            a_r   <= input_a;
            b_r   <= input_b;
            br_r  <= input_bin;
            cnt_r <= '0;
        end else if (shift_s) begin
            a_r   <= {1'b0, a_r[WIDTH-1:1]};
            b_r   <= {1'b0, b_r[WIDTH-1:1]};
            br_r  <= br_next_s;
            dif_r <= {d_s, dif_r[WIDTH-1:1]};
            cnt_r <= cnt_r + CNT_W'(1);
            // The parallel result only ever changes on the completion edge.
            if (finish_s) begin
                diff_r <= {d_s, dif_r[WIDTH-1:1]};
                bout_r <= br_next_s;
            end else begin
                diff_r <= diff_r;
                bout_r <= bout_r;
            end
        end else begin
            a_r <= a_r;
            b_r <= b_r;
        end
    end

    assign output_busy_o         = busy_r;
    assign output_done_o         = done_r;
    assign output_diff_o         = diff_r;
    assign output_bout_o         = bout_r;
    assign output_serial_o       = busy_r & d_s;
    assign output_serial_valid_o = busy_r;

endmodule
